// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared FSM state encoding and WIDTH range limits for the
//                bit-serial adder/subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

  localparam int C_WIDTH_MIN = 2;
  localparam int C_WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True when the requested operand width is supported.
  function automatic bit width_ok(input int w);
    return (w >= C_WIDTH_MIN) && (w <= C_WIDTH_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_full_adder_slice.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_slice
//  Description : Single-bit combinational full adder used as the serial
//                datapath slice.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and majority carry of the three input bits.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial two's-complement adder/subtractor. One result bit
//                per clock, LSB first, start/done handshake, registered
//                sum, carry-out and signed-overflow outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam bit             C_WIDTH_OK = width_ok(WIDTH);
  localparam int             CNT_W      = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(WIDTH - 1);

  if (!C_WIDTH_OK) begin : g_bad_width
    $error("serial_adder: WIDTH must lie in 2..32");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             w_s;
  logic             w_cout;

  full_adder_slice u_slice (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (w_s),
    .cout (w_cout)
  );

  // Next-state, datapath shifting and result capture.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        carry_d  = w_cout;
        res_sh_d = {w_s, res_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST) begin
          // carry_q is the carry into the MSB; XOR with its carry out
          // gives signed overflow.
          sum_d   = {w_s, res_sh_q[WIDTH-1:1]};
          cout_d  = w_cout;
          ovf_d   = carry_q ^ w_cout;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Status flags decode straight from the state register.
  always_comb begin
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
    sum       = sum_q;
    carry_out = cout_q;
    overflow  = ovf_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder (WIDTH=8 and WIDTH=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       st8 = 1'b0, sb8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       busy8, done8, co8, ov8;

  // WIDTH=3 instance
  logic       st3 = 1'b0, sb3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0, sum3;
  logic       busy3, done3, co3, ov3;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .sub(sb8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8), .overflow(ov8)
  );

  serial_adder #(.WIDTH(3)) u3 (
    .clk(clk), .rst(rst), .start(st3), .sub(sb3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .sum(sum3), .carry_out(co3), .overflow(ov3)
  );

  int checks   = 0;
  int failures = 0;
  int done8_cnt = 0;

  logic [33:0] q8[$];
  logic [33:0] q3[$];

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {overflow, carry_out, sum} from integer arithmetic.
  function automatic logic [33:0] model(input int w, input int ua, input int ub, input bit s);
    int m, half, r, sa, sb, sr;
    bit co, ov;
    m    = 1 << w;
    half = m / 2;
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    if (!s) begin
      r = ua + ub; co = (r >= m); sr = sa + sb;
    end else begin
      r = ua - ub; co = (ua >= ub); sr = sa - sb;
    end
    ov = (sr < -half) || (sr > half - 1);
    r  = ((r % m) + m) % m;
    return (34'(ov) << (w + 1)) | (34'(co) << w) | 34'(r);
  endfunction

  // Scoreboard pop on every done pulse.
  always @(negedge clk) begin
    if (done8) begin
      done8_cnt++;
      if (q8.size() == 0) chk("u8_unexpected_done", 34'd1, 34'd0);
      else chk("u8_result", {23'd0, ov8, co8, sum8}, q8.pop_front());
    end
    if (done3) begin
      if (q3.size() == 0) chk("u3_unexpected_done", 34'd1, 34'd0);
      else chk("u3_result", {28'd0, ov3, co3, sum3}, q3.pop_front());
    end
  end

  // Start one operation on u8 and check latency and busy duration.
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic is);
    int n, bn;
    a8 = ia; b8 = ib; sb8 = is; st8 = 1'b1;
    q8.push_back(model(8, int'(ia), int'(ib), is));
    @(posedge clk); #1;
    st8 = 1'b0; a8 = ~ia; b8 = ~ib; sb8 = ~is;
    n = 0; bn = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (busy8) bn++;
      if (done8) break;
    end
    chk("u8_latency", 34'(n), 34'd9);
    chk("u8_busy_cycles", 34'(bn), 34'd8);
    @(posedge clk); #1;
  endtask

  task automatic wait_done8(input string tag);
    int n;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (done8) break;
    end
    chk(tag, 34'(done8), 34'd1);
  endtask

  initial begin
    int base, n;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("u8_reset_outputs", {23'd0, busy8, done8, co8, ov8, sum8}, 34'd0);
    chk("u3_reset_outputs", {28'd0, busy3, done3, co3, ov3, sum3}, 34'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed add/sub cases
    run8(8'h05, 8'h03, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("u8_idle_hold", {23'd0, busy8, done8, co8, ov8, sum8}, 34'h008);
    @(posedge clk); #1;
    run8(8'hFF, 8'h01, 1'b0);
    run8(8'h7F, 8'h01, 1'b0);
    run8(8'h05, 8'h07, 1'b1);
    run8(8'h80, 8'h01, 1'b1);

    // Start during RUN is ignored
    base = done8_cnt;
    a8 = 8'h12; b8 = 8'h34; sb8 = 1'b0; st8 = 1'b1;
    q8.push_back(model(8, 'h12, 'h34, 1'b0));
    @(posedge clk); #1; st8 = 1'b0;
    repeat (2) @(posedge clk); #1;
    a8 = 8'hAA; b8 = 8'h99; sb8 = 1'b1; st8 = 1'b1;
    @(posedge clk); #1; st8 = 1'b0;
    wait_done8("u8_ignored_start_done");
    repeat (12) @(posedge clk); #1;
    chk("u8_single_done", 34'(done8_cnt - base), 34'd1);

    // Back-to-back with start held high
    a8 = 8'h21; b8 = 8'h43; sb8 = 1'b0; st8 = 1'b1;
    q8.push_back(model(8, 'h21, 'h43, 1'b0));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      a8 = 8'hC3; b8 = 8'h5A;
      n = 0;
      while (n < 20) begin
        @(negedge clk);
        n++;
        if (done8) break;
      end
      chk("u8_b2b_period", 34'(n), 34'd9);
      if (k < 2) begin
        a8 = 8'(8'h30 + k); b8 = 8'(8'h70 + 3 * k); sb8 = k[0];
        q8.push_back(model(8, int'(a8), int'(b8), sb8));
      end else begin
        st8 = 1'b0;
      end
    end
    @(posedge clk); #1;

    // Reset in the middle of an operation
    base = done8_cnt;
    a8 = 8'h11; b8 = 8'h22; sb8 = 1'b0; st8 = 1'b1;
    @(posedge clk); #1; st8 = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("u8_abort_outputs", {23'd0, busy8, done8, co8, ov8, sum8}, 34'd0);
    repeat (12) @(posedge clk); #1;
    chk("u8_abort_no_done", 34'(done8_cnt - base), 34'd0);
    run8(8'h10, 8'h20, 1'b0);

    // Exhaustive WIDTH=3 sweep
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 8; x++) begin
        for (int y = 0; y < 8; y++) begin
          a3 = 3'(x); b3 = 3'(y); sb3 = s[0]; st3 = 1'b1;
          q3.push_back(model(3, x, y, s[0]));
          @(posedge clk); #1; st3 = 1'b0;
          n = 0;
          while (n < 10) begin
            @(negedge clk);
            n++;
            if (done3) break;
          end
          if (n >= 10) chk("u3_timeout", 34'd0, 34'd1);
          @(posedge clk); #1;
        end
      end
    end

    repeat (3) @(posedge clk);
    chk("u8_queue_drained", 34'(q8.size()), 34'd0);
    chk("u3_queue_drained", 34'(q3.size()), 34'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
